// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared combinational ALU.
// Requester 0 is the integer execute path, requester 1 a secondary client
// (e.g. address/branch compare). One request is granted per cycle. The
// granted operands drive the ALU, and the ALU result is captured into a
// one-entry response register. That register is drained over a valid/ready
// handshake and tagged with the owning requester ID.

module alu_arbiter #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    // Request side
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [XLEN-1:0]   req0_src1,
    input  logic [XLEN-1:0]   req0_src2,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [XLEN-1:0]   req1_src1,
    input  logic [XLEN-1:0]   req1_src2,
    input  logic [CTRL_W-1:0] req1_ctrl,

    // Shared ALU
    output logic [XLEN-1:0]   alu_src1,
    output logic [XLEN-1:0]   alu_src2,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              alu_zero,

    // Response side
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [XLEN-1:0]   rsp_result,
    output logic              rsp_zero
);

    // Round-robin pointer: the requester that won the most recent transfer.
    logic            last_grant_q, last_grant_d;

    // One-entry response register
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_id_q, rsp_id_d;
    logic [XLEN-1:0] rsp_result_q, rsp_result_d;
    logic            rsp_zero_q, rsp_zero_d;

    logic       can_accept;
    logic [1:0] grant;
    logic       xfer;
    logic       xfer_id;

    // Arbitration: pick a winner among valid requesters, then gate on response space.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Contention goes to the requester that did not win last time.
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase

        // Space exists if the register is empty or is being drained this cycle.
        can_accept = !rsp_valid_q || rsp_ready;

        // rst_n gating keeps req_ready low throughout reset, not just after the first edge.
        req_ready = (can_accept && rst_n) ? grant : 2'b00;

        // req_ready is already qualified by req_valid via grant.
        xfer    = |(req_valid & req_ready);
        xfer_id = req_ready[1];
    end

    // ALU operand mux: granted requester's fields, otherwise all-zero (ADD 0+0).
    always_comb begin
        alu_src1 = '0;
        alu_src2 = '0;
        alu_ctrl = '0;
        if (req_ready[0]) begin
            alu_src1 = req0_src1;
            alu_src2 = req0_src2;
            alu_ctrl = req0_ctrl;
        end else if (req_ready[1]) begin
            alu_src1 = req1_src1;
            alu_src2 = req1_src2;
            alu_ctrl = req1_ctrl;
        end
    end

    // Next-state: a transfer overwrites the response register, else a drain clears valid.
    always_comb begin
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;

        if (xfer) begin
            // A simultaneous drain and new transfer keeps valid high for back-to-back throughput.
            last_grant_d = xfer_id;
            rsp_valid_d  = 1'b1;
            rsp_id_d     = xfer_id;
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
        end else if (rsp_valid_q && rsp_ready) begin
            // Payload fields hold their last values after a drain.
            rsp_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Pointer resets to 1 so the first contended grant goes to requester 0.
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a behavioural ALU plus a transaction-level
// reference model of arbitration and the response register. The bench runs
// a directed sequence followed by randomized traffic.

module tb_alu_arbiter;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [XLEN-1:0]   req0_src1, req0_src2, req1_src1, req1_src2;
    logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
    logic [XLEN-1:0]   alu_src1, alu_src2, alu_result;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              alu_zero;
    logic              rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [XLEN-1:0]   rsp_result;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    bit              m_last;
    bit              m_valid;
    bit              m_id;
    logic [XLEN-1:0] m_result;
    bit              m_zero;

    logic [1:0]      obs_ready;
    logic [XLEN-1:0] held;

    always #5 clk = ~clk;

    // Behavioural ALU; undefined codes return 0.
    function automatic logic [31:0] bench_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] c);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = bench_alu(alu_src1, alu_src2, alu_ctrl);
    assign alu_zero   = (alu_result == 32'd0);

    alu_arbiter #(
        .XLEN   (XLEN),
        .CTRL_W (CTRL_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_src1  (req0_src1),
        .req0_src2  (req0_src2),
        .req0_ctrl  (req0_ctrl),
        .req1_src1  (req1_src1),
        .req1_src2  (req1_src2),
        .req1_ctrl  (req1_ctrl),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last   = 1'b1;
        m_valid  = 1'b0;
        m_id     = 1'b0;
        m_result = '0;
        m_zero   = 1'b0;
    endtask

    // Called at the negedge with inputs already applied; returns at the following negedge.
    task automatic cycle();
        logic [1:0]      g;
        logic [XLEN-1:0] es1, es2, er;
        logic [3:0]      ec;
        bit              can;

        can = !m_valid || rsp_ready;
        g   = 2'b00;
        if (can) begin
            if (req_valid == 2'b11) g = m_last ? 2'b01 : 2'b10;
            else                    g = req_valid;
        end
        es1 = '0; es2 = '0; ec = '0;
        if (g == 2'b01) begin
            es1 = req0_src1; es2 = req0_src2; ec = req0_ctrl;
        end else if (g == 2'b10) begin
            es1 = req1_src1; es2 = req1_src2; ec = req1_ctrl;
        end
        er = bench_alu(es1, es2, ec);

        #1;
        obs_ready = req_ready;
        check("req_ready",  64'(req_ready),  64'(g));
        check("alu_src1",   64'(alu_src1),   64'(es1));
        check("alu_src2",   64'(alu_src2),   64'(es2));
        check("alu_ctrl",   64'(alu_ctrl),   64'(ec));
        check("rsp_valid",  64'(rsp_valid),  64'(m_valid));
        check("rsp_id",     64'(rsp_id),     64'(m_id));
        check("rsp_result", 64'(rsp_result), 64'(m_result));
        check("rsp_zero",   64'(rsp_zero),   64'(m_zero));

        @(posedge clk);
        if (g != 2'b00) begin
            m_last   = g[1];
            m_valid  = 1'b1;
            m_id     = g[1];
            m_result = er;
            m_zero   = (er == 32'd0);
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic set_req0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        req0_src1 = a; req0_src2 = b; req0_ctrl = c;
    endtask

    task automatic set_req1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        req1_src1 = a; req1_src2 = b; req1_ctrl = c;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        set_req0(32'd1, 32'd2, 4'd0);
        set_req1(32'd3, 32'd4, 4'd0);
        model_reset();

        // Reset state, with both requests valid
        #1;
        check("reset_req_ready",  64'(req_ready),  64'd0);
        check("reset_rsp_valid",  64'(rsp_valid),  64'd0);
        check("reset_rsp_id",     64'(rsp_id),     64'd0);
        check("reset_rsp_result", 64'(rsp_result), 64'd0);
        check("reset_rsp_zero",   64'(rsp_zero),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention from reset: grants alternate 0,1,0,1 with ids one cycle later
        cycle(); check("cont_g0", 64'(obs_ready), 64'd1);
        check("cont_id0", 64'(rsp_id), 64'd0);
        cycle(); check("cont_g1", 64'(obs_ready), 64'd2);
        check("cont_id1", 64'(rsp_id), 64'd1);
        cycle(); check("cont_g2", 64'(obs_ready), 64'd1);
        check("cont_id2", 64'(rsp_id), 64'd0);
        cycle(); check("cont_g3", 64'(obs_ready), 64'd2);
        check("cont_id3", 64'(rsp_id), 64'd1);

        // Single request: 5 + 3
        req_valid = 2'b01;
        set_req0(32'd5, 32'd3, 4'd0);
        cycle(); check("add_ready", 64'(obs_ready), 64'd1);
        check("add_valid",  64'(rsp_valid),  64'd1);
        check("add_id",     64'(rsp_id),     64'd0);
        check("add_result", 64'(rsp_result), 64'd8);
        check("add_zero",   64'(rsp_zero),   64'd0);

        // SUB with equal operands on requester 1
        req_valid = 2'b10;
        set_req1(32'd7, 32'd7, 4'd1);
        cycle();
        check("sub_result", 64'(rsp_result), 64'd0);
        check("sub_zero",   64'(rsp_zero),   64'd1);
        check("sub_id",     64'(rsp_id),     64'd1);

        // Backpressure: load a response from requester 0, then stall 3 cycles
        req_valid = 2'b01;
        set_req0(32'h1234, 32'h1, 4'd0);
        cycle();
        held      = rsp_result;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_ready",  64'(obs_ready),  64'd0);
            check("bp_result", 64'(rsp_result), 64'(held));
        end
        rsp_ready = 1'b1;
        cycle(); check("bp_release_grant", 64'(obs_ready), 64'd2);

        // Signed compare: -1 < 1
        req_valid = 2'b01;
        set_req0(32'hFFFF_FFFF, 32'd1, 4'd5);
        cycle(); check("slt_result", 64'(rsp_result), 64'd1);

        // Idle cycles keep the pointer; last winner was 0 so contention goes to 1
        req_valid = 2'b00;
        repeat (3) cycle();
        req_valid = 2'b11;
        cycle(); check("idle_fair_grant", 64'(obs_ready), 64'd2);

        // Mid-operation reset
        req_valid = 2'b01;
        cycle();
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        check("pre_reset_valid", 64'(rsp_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(rsp_valid), 64'd0);
        check("midrst_ready", 64'(req_ready), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        cycle(); check("post_reset_grant", 64'(obs_ready), 64'd1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 3) != 0);
            set_req0($urandom, ($urandom_range(0, 3) == 0) ? req0_src1 : $urandom,
                     4'($urandom_range(0, 15)));
            set_req1($urandom_range(0, 20), $urandom_range(0, 20), 4'($urandom_range(0, 15)));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
